// File: rtl/psum_path_arbiter.sv
//------------------------------------------------------------------------------
// psum_path_arbiter
//   Round-robin merge of NSRC partial-sum sources onto a single registered
//   output channel with rdy/ack handshakes, per-source enables and a
//   pass-length beat counter.
//   Optional build macro: PSUM_PATH_ADD_EN (merges sources 0 and 1 lane-wise
//   when both request with matching conf tags).
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module psum_path_arbiter #(
    parameter int NSRC    = 2,
    parameter int PEROW   = 4,
    parameter int PSUMDWD = 16,
    parameter int CONFW   = 8,
    parameter int CNTW    = 6,
    localparam int SRCW   = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int LANEW  = PEROW * PSUMDWD
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NSRC-1:0]         i_src_rdy,
    output logic [NSRC-1:0]         o_src_ack,
    input  logic [NSRC*LANEW-1:0]   i_src_psum,
    input  logic [NSRC*CONFW-1:0]   i_src_conf,
    input  logic [NSRC-1:0]         i_src_en,
    output logic                    o_pout_rdy,
    input  logic                    i_pout_ack,
    output logic [LANEW-1:0]        o_pout_psum,
    output logic [CONFW-1:0]        o_pout_conf,
    output logic [SRCW-1:0]         o_pout_src,
    input  logic [CNTW-1:0]         i_pass_len,
    output logic [CNTW-1:0]         o_pass_idx,
    output logic                    o_pass_last
);

    logic              r_full;
    logic [SRCW-1:0]   r_ptr;
    logic [CNTW-1:0]   r_idx;
    logic [CNTW-1:0]   r_len;

    logic [NSRC-1:0]   w_req;
    logic              w_can_load;
    logic              w_xfer;
    logic              w_hi_found;
    logic              w_lo_found;
    logic [SRCW-1:0]   w_hi_idx;
    logic [SRCW-1:0]   w_lo_idx;
    logic              w_rr_found;
    logic [SRCW-1:0]   w_rr_idx;
    logic [LANEW-1:0]  w_sel_psum;
    logic [CONFW-1:0]  w_sel_conf;
    logic              w_load;
    logic [LANEW-1:0]  w_load_psum;
    logic [CONFW-1:0]  w_load_conf;
    logic [SRCW-1:0]   w_load_src;
    logic [SRCW-1:0]   w_next_ptr;
    logic [CNTW-1:0]   w_len_sel;
    logic [CNTW-1:0]   w_len_eff;
    logic              w_idx_last;

    assign w_req      = i_src_rdy & i_src_en;
    assign w_xfer     = r_full && i_pout_ack;
    assign w_can_load = !r_full || i_pout_ack;

`ifdef PSUM_PATH_ADD_EN
    logic [LANEW-1:0]  w_sum_psum;
    logic              w_merge;

    for (genvar r = 0; r < PEROW; r++) begin : g_lane_add
        assign w_sum_psum[r*PSUMDWD +: PSUMDWD] =
            i_src_psum[r*PSUMDWD +: PSUMDWD] + i_src_psum[(PEROW+r)*PSUMDWD +: PSUMDWD];
    end

    assign w_merge = w_req[0] && w_req[1] &&
                     (i_src_conf[0 +: CONFW] == i_src_conf[CONFW +: CONFW]);
`endif

    // Round-robin search: lowest requester at or above ptr, else lowest below it
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_sel_psum = '0;
        w_sel_conf = '0;
        for (int s = NSRC - 1; s >= 0; s--) begin
            if (w_req[s]) begin
                if (s >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SRCW'(s);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = SRCW'(s);
                end
            end
        end
        w_rr_found = w_hi_found || w_lo_found;
        w_rr_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
        for (int s = 0; s < NSRC; s++) begin
            if (w_rr_idx == SRCW'(s)) begin
                w_sel_psum = i_src_psum[s*LANEW +: LANEW];
                w_sel_conf = i_src_conf[s*CONFW +: CONFW];
            end
        end
    end

    // Grant decision: same-cycle acks, load payload and next pointer
    always_comb begin
        o_src_ack   = '0;
        w_load      = 1'b0;
        w_load_psum = w_sel_psum;
        w_load_conf = w_sel_conf;
        w_load_src  = w_rr_idx;
        w_next_ptr  = (w_rr_idx == SRCW'(NSRC - 1)) ? '0 : w_rr_idx + 1'b1;
        // Acks are held low while reset is asserted so nothing is accepted and dropped
        if (i_rst_n && w_can_load) begin
`ifdef PSUM_PATH_ADD_EN
            if (w_merge) begin
                o_src_ack[0] = 1'b1;
                o_src_ack[1] = 1'b1;
                w_load       = 1'b1;
                w_load_psum  = w_sum_psum;
                w_load_conf  = i_src_conf[0 +: CONFW];
                w_load_src   = '0;
                w_next_ptr   = SRCW'(2 % NSRC);
            end else
`endif
            if (w_rr_found) begin
                w_load = 1'b1;
                for (int s = 0; s < NSRC; s++) begin
                    o_src_ack[s] = (w_rr_idx == SRCW'(s));
                end
            end
        end
    end

    // Output register, full flag and arbitration pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full      <= 1'b0;
            r_ptr       <= '0;
            o_pout_psum <= '0;
            o_pout_conf <= '0;
            o_pout_src  <= '0;
        end else if (w_load) begin
            r_full      <= 1'b1;
            r_ptr       <= w_next_ptr;
            o_pout_psum <= w_load_psum;
            o_pout_conf <= w_load_conf;
            o_pout_src  <= w_load_src;
        end else if (w_xfer) begin
            r_full      <= 1'b0;
        end
    end

    // At beat 0 the live pass length applies; later beats use the latched one
    assign w_len_sel  = (r_idx == '0) ? i_pass_len : r_len;
    assign w_len_eff  = (w_len_sel == '0) ? CNTW'(1) : w_len_sel;
    assign w_idx_last = (r_idx == w_len_eff - 1'b1);

    // Pass beat counter advancing on every output transfer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
            r_len <= '0;
        end else if (w_xfer) begin
            if (r_idx == '0) begin
                r_len <= i_pass_len;
            end
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end
    end

    assign o_pout_rdy  = r_full;
    assign o_pass_idx  = r_idx;
    assign o_pass_last = r_full && w_idx_last;

endmodule

`default_nettype wire

// File: tb/tb_psum_path_arbiter.sv
//------------------------------------------------------------------------------
// tb_psum_path_arbiter
//   Scoreboard bench: a reference model predicts acks and pushes expected beats;
//   a monitor pops and compares on every output transfer.
//------------------------------------------------------------------------------
`default_nettype none

module tb_psum_path_arbiter;

    localparam int NSRC    = 2;
    localparam int PEROW   = 4;
    localparam int PSUMDWD = 16;
    localparam int CONFW   = 8;
    localparam int CNTW    = 6;
    localparam int SRCW    = 1;
    localparam int LANEW   = PEROW * PSUMDWD;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NSRC-1:0]       src_rdy;
    logic [NSRC-1:0]       src_ack;
    logic [NSRC*LANEW-1:0] src_psum;
    logic [NSRC*CONFW-1:0] src_conf;
    logic [NSRC-1:0]       src_en;
    logic                  pout_rdy;
    logic                  pout_ack;
    logic [LANEW-1:0]      pout_psum;
    logic [CONFW-1:0]      pout_conf;
    logic [SRCW-1:0]       pout_src;
    logic [CNTW-1:0]       pass_len;
    logic [CNTW-1:0]       pass_idx;
    logic                  pass_last;

    psum_path_arbiter #(
        .NSRC(NSRC), .PEROW(PEROW), .PSUMDWD(PSUMDWD), .CONFW(CONFW), .CNTW(CNTW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_src_rdy(src_rdy), .o_src_ack(src_ack),
        .i_src_psum(src_psum), .i_src_conf(src_conf), .i_src_en(src_en),
        .o_pout_rdy(pout_rdy), .i_pout_ack(pout_ack),
        .o_pout_psum(pout_psum), .o_pout_conf(pout_conf), .o_pout_src(pout_src),
        .i_pass_len(pass_len), .o_pass_idx(pass_idx), .o_pass_last(pass_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANEW-1:0] psum;
        logic [CONFW-1:0] conf;
        int               src;
    } beat_t;

    beat_t           sb[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    bit              in_reset = 1'b1;
    int              m_ptr = 0;
    bit              m_full = 1'b0;
    int              m_idx = 0;
    int              m_len = 1;
    int              xfer_cnt = 0;
    int              ack_cnt[NSRC];
    logic [NSRC-1:0] ack_seen = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each output transfer against the oldest expected beat
    always @(negedge clk) begin
        if (!in_reset) begin
            check("pout_rdy", 64'(pout_rdy), 64'(sb.size() > 0));
            if (pout_rdy && pout_ack && sb.size() > 0) begin
                beat_t e;
                e = sb.pop_front();
                xfer_cnt++;
                check("pout_psum", pout_psum, e.psum);
                check("pout_conf", 64'(pout_conf), 64'(e.conf));
                check("pout_src", 64'(pout_src), 64'(e.src));
                if (m_idx == 0) m_len = (pass_len == 0) ? 1 : int'(pass_len);
                check("pass_idx", 64'(pass_idx), 64'(m_idx));
                check("pass_last", 64'(pass_last), 64'(m_idx == m_len - 1));
                m_idx = (m_idx + 1) % m_len;
            end else if (!pout_rdy) begin
                check("pass_last_idle", 64'(pass_last), 64'd0);
            end
        end
    end

    // Reference model: predict acks from the arbitration rules, push expected beats
    always @(negedge clk) begin
        if (!in_reset) begin
            logic [NSRC-1:0]  req;
            logic [NSRC-1:0]  exp_ack;
            beat_t            nb;
            bit               load;
            int               best;
            #1;
            req     = src_rdy & src_en;
            exp_ack = '0;
            load    = 1'b0;
            nb.psum = '0;
            nb.conf = '0;
            nb.src  = 0;
            if (!m_full || pout_ack) begin
`ifdef PSUM_PATH_ADD_EN
                if (req[0] && req[1] && src_conf[0 +: CONFW] == src_conf[CONFW +: CONFW]) begin
                    exp_ack = '0;
                    exp_ack[0] = 1'b1;
                    exp_ack[1] = 1'b1;
                    load = 1'b1;
                    for (int r = 0; r < PEROW; r++)
                        nb.psum[r*PSUMDWD +: PSUMDWD] = src_psum[r*PSUMDWD +: PSUMDWD]
                                                      + src_psum[(PEROW+r)*PSUMDWD +: PSUMDWD];
                    nb.conf = src_conf[0 +: CONFW];
                    nb.src  = 0;
                    m_ptr   = 2 % NSRC;
                end else
`endif
                begin
                    best = -1;
                    for (int d = 0; d < NSRC; d++) begin
                        if (best < 0 && req[(m_ptr + d) % NSRC]) best = (m_ptr + d) % NSRC;
                    end
                    if (best >= 0) begin
                        exp_ack[best] = 1'b1;
                        load    = 1'b1;
                        nb.psum = src_psum[best*LANEW +: LANEW];
                        nb.conf = src_conf[best*CONFW +: CONFW];
                        nb.src  = best;
                        m_ptr   = (best + 1) % NSRC;
                    end
                end
            end
            check("src_ack", 64'(src_ack), 64'(exp_ack));
            ack_seen = src_ack;
            for (int s = 0; s < NSRC; s++) ack_cnt[s] += int'(src_ack[s]);
            if (load) sb.push_back(nb);
            m_full = load ? 1'b1 : ((m_full && pout_ack) ? 1'b0 : m_full);
        end
    end

    // Advance one cycle; a source drops rdy once its beat has been accepted
    task automatic step();
        @(posedge clk);
        #1;
        for (int s = 0; s < NSRC; s++) if (ack_seen[s]) src_rdy[s] = 1'b0;
    endtask

    task automatic set_src(int s, logic [LANEW-1:0] p, logic [CONFW-1:0] c);
        src_psum[s*LANEW +: LANEW] = p;
        src_conf[s*CONFW +: CONFW] = c;
        src_rdy[s] = 1'b1;
    endtask

    task automatic run_random(int cycles, int p_rdy, int p_ack, bit rand_en);
        repeat (cycles) begin
            step();
            for (int s = 0; s < NSRC; s++)
                if (!src_rdy[s] && $urandom_range(0, 99) < p_rdy)
                    set_src(s, {$urandom, $urandom}, CONFW'($urandom_range(0, 3)));
            pout_ack = ($urandom_range(0, 99) < p_ack);
            if (rand_en)
                for (int s = 0; s < NSRC; s++) src_en[s] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 4) pass_len = CNTW'($urandom_range(0, 5));
        end
    endtask

    task automatic drain();
        src_rdy  = '0;
        pout_ack = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        int a0, a1, x0;
        for (int s = 0; s < NSRC; s++) ack_cnt[s] = 0;
        rst_n    = 1'b0;
        src_rdy  = '0;
        src_psum = '0;
        src_conf = '0;
        src_en   = '1;
        pout_ack = 1'b0;
        pass_len = 6'd3;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        set_src(0, 64'h1234, 8'd0);
        #1;
        check("rst_pout_rdy", 64'(pout_rdy), 64'd0);
        check("rst_src_ack", 64'(src_ack), 64'd0);
        check("rst_pout_psum", pout_psum, 64'd0);
        check("rst_pass_idx", 64'(pass_idx), 64'd0);
        src_rdy = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_reset = 1'b0;

        // Both sources continuously ready, output always accepting
        pout_ack = 1'b1;
        x0 = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            for (int s = 0; s < NSRC; s++)
                if (!src_rdy[s]) set_src(s, {$urandom, $urandom}, CONFW'(s));
            if (c == 2) x0 = xfer_cnt;
        end
        check("throughput", 64'(xfer_cnt - x0), 64'd9);
        drain();

        // Output stall: exactly one ack, data held
        step();
        set_src(1, 64'h0004_0003_0002_0001, 8'd7);
        pout_ack = 1'b0;
        a1 = ack_cnt[1];
        repeat (6) begin
            step();
            if (!src_rdy[1]) set_src(1, 64'h0009_0009_0009_0009, 8'd7);
        end
        check("stall_ack_count", 64'(ack_cnt[1] - a1), 64'd1);
        check("stall_hold_psum", pout_psum, 64'h0004_0003_0002_0001);
        pout_ack = 1'b1;
        drain();

        // Source 1 disabled while ready
        src_en = 2'b01;
        a0 = ack_cnt[0];
        a1 = ack_cnt[1];
        for (int c = 0; c < 20; c++) begin
            step();
            for (int s = 0; s < NSRC; s++)
                if (!src_rdy[s]) set_src(s, {$urandom, $urandom}, CONFW'(s));
            pout_ack = ($urandom_range(0, 1) == 1);
        end
        check("disabled_src1_acks", 64'(ack_cnt[1] - a1), 64'd0);
        check("enabled_src0_progress", 64'(ack_cnt[0] - a0 > 3), 64'd1);
        src_en = '1;
        drain();

        // Pass length 3 then changed to 5 mid-pass
        pass_len = 6'd3;
        run_random(30, 80, 100, 1'b0);
        pass_len = 6'd5;
        run_random(30, 80, 70, 1'b0);

`ifdef PSUM_PATH_ADD_EN
        // Merge of sources 0 and 1 with equal conf
        drain();
        step();
        set_src(0, 64'h0028_001E_0014_000A, 8'd5);
        set_src(1, 64'hFFFF_0003_0002_0001, 8'd5);
        @(negedge clk);
        #2;
        check("merge_acks", 64'(src_ack), 64'h3);
        step();
        check("merge_sum", pout_psum, 64'h0027_0021_0016_000B);
        check("merge_src", 64'(pout_src), 64'd0);
`endif

        // Random traffic with random enables, backpressure and pass lengths
        run_random(400, 60, 60, 1'b1);
        src_en = '1;
        drain();

        // Asynchronous reset while full with a beat pending
        step();
        set_src(1, 64'hAAAA_BBBB_CCCC_DDDD, 8'd1);
        pout_ack = 1'b0;
        step();
        #2;
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_rst_rdy", 64'(pout_rdy), 64'd0);
        check("async_rst_psum", pout_psum, 64'd0);
        check("async_rst_conf", 64'(pout_conf), 64'd0);
        check("async_rst_ack", 64'(src_ack), 64'd0);
        check("async_rst_last", 64'(pass_last), 64'd0);
        sb.delete();
        m_full = 1'b0;
        m_ptr = 0;
        m_idx = 0;
        ack_seen = '0;
        step();
        set_src(0, 64'h1111, 8'd0);
        set_src(1, 64'h2222, 8'd1);
        pout_ack = 1'b1;
        rst_n = 1'b1;
        in_reset = 1'b0;
        @(negedge clk);
        #2;
        check("first_grant_after_reset", 64'(src_ack), 64'h1);
        run_random(60, 70, 80, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/psum_path_arbiter.md
Name: psum_path_arbiter

Overview:
- Parametrised successor to the PE partial-sum path stage.
- Merges NSRC partial-sum sources (PP buffer, left PE, extra neighbours) onto one registered output channel.
- Arbitration is round-robin under rdy/ack handshakes, with a per-source enable and a pass-length beat counter.
- Sits between the PE datapath and the downstream psum consumer (next PE / output buffer).

Parameters:
- NSRC, 2, number of input sources (2..8)
- PEROW, 4, psum lanes per beat
- PSUMDWD, 16, bits per psum lane
- CONFW, 8, width of the per-beat conf tag carried with the psums
- CNTW, 6, width of the pass-length counter (max pass 2^CNTW-1)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_src_rdy  in  NSRC  per-source valid
- o_src_ack  out  NSRC  per-source accept, one-hot or zero
- i_src_psum  in  NSRC*PEROW*PSUMDWD  source s lane r at bits [(s*PEROW+r)*PSUMDWD +: PSUMDWD]
- i_src_conf  in  NSRC*CONFW  source s tag at [s*CONFW +: CONFW]
- i_src_en  in  NSRC  eligibility mask; a disabled source is never acked
- o_pout_rdy  out  1  output valid
- i_pout_ack  in  1  output accept
- o_pout_psum  out  PEROW*PSUMDWD  registered psum vector
- o_pout_conf  out  CONFW  registered tag
- o_pout_src  out  max(1,$clog2(NSRC))  index of the source that produced the beat
- i_pass_len  in  CNTW  beats per pass, sampled when the beat index is 0
- o_pass_idx  out  CNTW  index of the current output beat within the pass
- o_pass_last  out  1  o_pout_rdy && current beat is last of the pass

Behaviour:
- Handshake: a transfer occurs on a channel when rdy && ack are high in the same cycle. Sources hold rdy and data stable until acked.
- Output register: one entry with a full flag.
  - can_load = !full || (o_pout_rdy && i_pout_ack).
  - Requesting sources: req[s] = i_src_rdy[s] && i_src_en[s].
  - If can_load && |req: grant one source, assert its o_src_ack combinationally in the same cycle, and load psum, conf and src index on the next edge.
  - full is set on load and cleared on an output transfer with no simultaneous load.
  - Latency: source accept to o_pout_rdy is 1 cycle.
  - Sustained throughput is 1 beat/cycle while i_pout_ack is held high.
- Arbitration: round-robin pointer ptr (reset 0).
  - Grant the first req index at or after ptr, wrapping modulo NSRC.
  - After a grant, ptr = granted+1 (wraps at NSRC-1 -> 0). ptr is unchanged if there is no grant.
  - No ack is issued while full && !i_pout_ack (backpressure). Output data then holds stable.
- Pass counter:
  - len_r is latched from i_pass_len on each output transfer while idx==0, and at reset; len 0 is treated as 1.
  - idx increments on each output transfer and wraps to 0 after the beat where idx==len_r-1.
  - o_pass_last = o_pout_rdy && (idx==len_r-1).
- Reset (asynchronous, any time, including mid-transfer):
  - full=0, ptr=0, idx=0, len_r=0.
  - o_pout_psum='0, o_pout_conf='0, o_pout_src=0.
  - o_pout_rdy=0, o_src_ack=0, o_pass_last=0.
  - In-flight beats are dropped.
- Boundaries:
  - All req low: no load. o_pout_rdy falls after the pending beat drains.
  - Simultaneous output transfer and load: full stays 1, data is replaced, and idx still advances.
  - A source disabled while rdy: it is skipped and ptr is not stalled on it.

Optional Feature:
- Macro PSUM_PATH_ADD_EN.
- Defined: merge mode.
  - Condition: req[0] && req[1] && conf0==conf1 && can_load.
  - Both o_src_ack[0] and [1] assert in the same cycle.
  - The loaded beat is the lane-wise sum src0+src1, truncated to PSUMDWD (wrap, no saturation).
  - o_pout_src=0 and ptr=2 mod NSRC.
  - Merge takes priority over round-robin.
- Undefined: pure round-robin as above. No adders are synthesised.

Test Plan:
- Reset then NSRC=2, both rdy continuously, i_pout_ack=1 -> acks alternate src0,src1,src0,...; o_pout_src alternates; one beat per cycle after 1-cycle latency.
- Output stall: src1 rdy with psum lanes {1,2,3,4}, i_pout_ack=0 for 5 cycles -> exactly one ack; o_pout_psum holds {1,2,3,4}; no further ack until i_pout_ack=1.
- i_src_en=2'b01 with both rdy -> only src0 acked; src1 never acked; ptr cycles without deadlock.
- i_pass_len=3, 7 output beats -> o_pass_idx 0,1,2,0,1,2,0; o_pass_last high on beats 3 and 6 only; i_pass_len changed to 5 mid-pass takes effect at the next idx 0.
- Assert i_rst_n low while full with ack pending -> o_pout_rdy=0 and outputs '0 immediately; after release the first grant goes to src0.
- PSUM_PATH_ADD_EN: src0={10,20,30,40}, src1={1,2,3,0xFFFF}, equal conf -> both acked in the same cycle; output {11,22,33,39}.
